// File: rtl/alu_sequencer.sv
// Command-issuing sequencer for a 16-bit ALU: runs a 16-entry program held in local memory
// against a 4-entry register file, one FETCH/ISSUE/WB triple per instruction.
module alu_sequencer #(
  parameter int unsigned W  = 16,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [11:0]   prog_data,
  input  logic          reg_we,
  input  logic [1:0]    reg_addr,
  input  logic [W-1:0]  reg_wdata,
  input  logic          start,
  input  logic [1:0]    rd_addr,
  output logic [W-1:0]  rd_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] pc,
  output logic [W-1:0]  alu_input1,
  output logic [W-1:0]  alu_input2,
  output logic [3:0]    alu_opcode,
  input  logic [W-1:0]  alu_result
);

  localparam int unsigned   DEPTH   = 2 ** AW;
  localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);
  localparam logic [3:0]    OP_NOOP = 4'h0;
  localparam logic [3:0]    OP_DIV  = 4'h4;
  localparam logic [3:0]    OP_HALT = 4'h9;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_WB} state_t;

  state_t      state;
  logic [9:0]  mem [DEPTH];
  logic [9:0]  ir;
  logic [W-1:0] regs [4];

  logic [3:0]  ir_op;
  logic [1:0]  ir_dst;
  logic [1:0]  ir_sa;
  logic [1:0]  ir_sb;
  logic        op_illegal;
  logic        div_zero;
  logic        host_ok;
  logic        unused_pad;

  // The two low instruction bits are always zero, so only [11:2] is stored.
  assign unused_pad = ^prog_data[1:0];

  assign {ir_op, ir_dst, ir_sa, ir_sb} = ir;
  assign op_illegal = (ir_op >= 4'hA) && (ir_op <= 4'hE);
  assign div_zero   = (ir_op == OP_DIV) && (regs[ir_sb] == '0);
  assign host_ok    = (state == S_IDLE);
  assign rd_data    = regs[rd_addr];

  // Program memory survives reset; writes only land while idle.
  always_ff @(posedge clk) begin
    if (prog_we && host_ok) mem[prog_addr] <= prog_data[11:2];
  end

  // Sequencer state, register file and all registered outputs.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state      <= S_IDLE;
      ir         <= '0;
      pc         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      alu_input1 <= '0;
      alu_input2 <= '0;
      alu_opcode <= OP_NOOP;
      regs       <= '{default: '0};
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (reg_we) regs[reg_addr] <= reg_wdata;
          if (start) begin
            pc    <= '0;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          ir    <= mem[pc];
          state <= S_ISSUE;
        end
        S_ISSUE: begin
          alu_input1 <= regs[ir_sa];
          alu_input2 <= regs[ir_sb];
          // HALT and faults finish here with pc left on the current instruction.
          if ((ir_op == OP_HALT) || op_illegal || div_zero) begin
            alu_opcode <= OP_NOOP;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= S_IDLE;
            if (op_illegal || div_zero) err <= 1'b1;
          end else begin
            alu_opcode <= ir_op;
            state      <= S_WB;
          end
        end
        S_WB: begin
          if (ir_op != OP_NOOP) regs[ir_dst] <= alu_result;
          alu_opcode <= OP_NOOP;
          if (pc == PC_LAST) begin
            pc    <= '0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            pc    <= pc + AW'(1);
            state <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
